// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: decode-flag bit positions,
// FSM state encoding and the writeback-source select.
package mem_stage_pkg;

    localparam int CTRL_W = 10;

    // ex_ctrl bit positions; the first-listed flag (compute) sits in the MSB
    localparam int CTRL_HLT         = 0;
    localparam int CTRL_PCS         = 1;
    localparam int CTRL_BR          = 2;
    localparam int CTRL_B           = 3;
    localparam int CTRL_LLB         = 4;
    localparam int CTRL_LHB         = 5;
    localparam int CTRL_SW          = 6;
    localparam int CTRL_LW          = 7;
    localparam int CTRL_COMPUTE_IMM = 8;
    localparam int CTRL_COMPUTE     = 9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'd0,
        WB_SEL_MEM = 2'd1,
        WB_SEL_PC  = 2'd2
    } wb_sel_t;

    function automatic wb_sel_t wb_select(input logic [CTRL_W-1:0] ctrl);
        if (ctrl[CTRL_LW])
            return WB_SEL_MEM;
        else if (ctrl[CTRL_PCS])
            return WB_SEL_PC;
        else
            return WB_SEL_ALU;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for an outstanding memory transfer: clears when idle, counts while enabled,
// saturates at all-ones. hit is combinational from the count (same-cycle timeout compare).
module mem_wait_timer #(
    parameter int CNT_W   = 7,
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != CNT_MAX)
            cnt <= cnt + 1'b1;
    end

    assign hit = (cnt == CNT_LAST);

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: LW/SW over a req/ack port, writeback registered into MEM/WB (1 cycle).
// Holds upstream via stall while a transfer is outstanding; aborts after TIMEOUT wait cycles.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 4,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  ex_pc,
    input  logic [DATA_W-1:0]  ex_alu,
    input  logic [15:0]        ex_instr,
    input  logic [DATA_W-1:0]  ex_rf2,
    input  logic [CTRL_W-1:0]  ex_ctrl,
    output logic               stall,
    output logic               mem_req,
    output logic               mem_we,
    output logic [DATA_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic               mem_ack,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               wb_wen,
    output logic [RADDR_W-1:0] wb_dst,
    output logic [DATA_W-1:0]  wb_data,
    output logic               wb_hlt,
    output logic               mem_err
);

    state_t            state;
    logic              valid;
    logic              is_mem;
    logic              busy;
    logic              hit;
    logic              timeout;
    logic              wen_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic              unused_instr_bits;

    assign valid   = |ex_ctrl;
    assign is_mem  = valid & (ex_ctrl[CTRL_LW] | ex_ctrl[CTRL_SW]);
    assign busy    = (state == ST_BUSY);
    assign timeout = busy & hit & ~mem_ack;

    // Gated by rst so the request drops the instant reset asserts, even with a LW still presented.
    assign mem_req   = rst & ((~busy & is_mem) | busy) & ~timeout;
    assign stall     = mem_req & ~mem_ack;
    assign mem_we    = ex_ctrl[CTRL_SW];
    assign mem_addr  = ex_alu;
    assign mem_wdata = ex_rf2;

    assign unused_instr_bits = ^{ex_instr[15:12], ex_instr[7:0]};

    mem_wait_timer #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (~busy),
        .en  (busy),
        .hit (hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (mem_req && !mem_ack) state <= ST_BUSY;
                ST_BUSY: if (mem_ack || timeout)  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            mem_err <= 1'b0;
        else if (timeout)
            mem_err <= 1'b1;
    end

    assign wen_nxt = ex_ctrl[CTRL_COMPUTE] | ex_ctrl[CTRL_COMPUTE_IMM] | ex_ctrl[CTRL_LW]
                   | ex_ctrl[CTRL_LHB] | ex_ctrl[CTRL_LLB] | ex_ctrl[CTRL_PCS];

    always_comb begin
        data_nxt = ex_alu;
        case (wb_select(ex_ctrl))
            WB_SEL_MEM: data_nxt = mem_rdata;
            WB_SEL_PC:  data_nxt = ex_pc;
            default:    data_nxt = ex_alu;
        endcase
    end

    // A stalled or aborted instruction retires into WB as a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_wen  <= 1'b0;
            wb_dst  <= '0;
            wb_data <= '0;
            wb_hlt  <= 1'b0;
        end else if (stall || timeout) begin
            wb_wen  <= 1'b0;
            wb_dst  <= '0;
            wb_data <= '0;
            wb_hlt  <= 1'b0;
        end else begin
            wb_wen  <= wen_nxt;
            wb_dst  <= ex_instr[11:8];
            wb_data <= data_nxt;
            wb_hlt  <= ex_ctrl[CTRL_HLT];
        end
    end

endmodule
